shift_add_mult4: RTL and testbench
==================================

// Module: shift_add_mult4
// PURPOSE
//  - Sequential shift-and-add unsigned multiplier; sits directly upstream of the WIDTH-bit ripple adder.
//  - Drives the adder operands every cycle and consumes its sum and carry-out.
//  - Forms one partial product per clock; delivers a 2*WIDTH-bit product with a done pulse.
//  - Feeds switch/LED and 7-segment paths on the Nexys A7 lab top level.
// PARAMETERS
//  - WIDTH  4  operand width; must equal the attached adder width; product is 2*WIDTH bits.
// PORTS
//  - clk       in   1        system clock, rising-edge.
//  - rst       in   1        asynchronous, active-high reset.
//  - start     in   1        request; sampled only in IDLE or DONE.
//  - a_in      in   WIDTH    multiplicand; captured on the accepted start edge.
//  - b_in      in   WIDTH    multiplier; captured on the accepted start edge.
//  - add_a     out  WIDTH    adder operand A = acc_hi (combinational from registers).
//  - add_b     out  WIDTH    adder operand B = mplr[0] ? mcand : 0.
//  - add_sum   in   WIDTH    adder sum, combinational return.
//  - add_cout  in   1        adder carry-out, combinational return.
//  - product   out  2*WIDTH  result; valid from done, held until the next accepted start.
//  - busy      out  1        high while in RUN.
//  - done      out  1        one-cycle pulse, high while in DONE.
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
//  - Reset values: state=IDLE; acc_hi, mplr, mcand, cnt = 0; product=0; busy=0; done=0.
//  - Reset mid-operation aborts the multiply immediately; no done pulse follows.
//  - States:
//    - IDLE: waits for start.
//    - RUN: WIDTH steps.
//    - DONE: one cycle, then IDLE.
//  - Accepted start at edge E0 (state IDLE or DONE, start=1):
//    - mcand<=a_in, mplr<=b_in, acc_hi<=0, cnt<=0, state<=RUN.
//  - RUN step at each edge E1..E(WIDTH):
//    - {acc_hi, mplr} <= {add_cout, add_sum, mplr[WIDTH-1:1]}.
//    - cnt <= cnt+1.
//    - When mplr[0]=0, add_b=0, so the step is a pure right shift through the adder.
//  - At E(WIDTH): product <= {add_cout, add_sum, mplr[WIDTH-1:1]}; state<=DONE.
//  - Latency: done high in the cycle after E(WIDTH), i.e. WIDTH+1 edges after start is sampled.
//  - Throughput: one product per WIDTH+1 cycles.
//  - Product width: 2*WIDTH bits; no overflow is possible; the adder carry is always retained.
//  - start while in RUN is ignored; it is neither queued nor restarted.
//  - start in DONE:
//    - Accepted as a new E0 (back-to-back operation).
//    - done still pulses for exactly that one cycle.
//    - product is overwritten only at the next completion.
//  - a_in and b_in are don't-care except on the accepted start edge.
//  - cnt width is clog2(WIDTH)+1; it never wraps inside RUN.
//  - busy=(state==RUN); done=(state==DONE); both are registered-state decodes with no glitch paths.
// CONFIGURATION
//  - Macro: MULT_ZERO_SKIP_EN.
//  - Defined: at an accepted start with a_in==0 or b_in==0:
//    - state goes directly to DONE and product <= 0 at E0.
//    - done is high in the cycle after E0; busy never asserts.
//  - Not defined: zero operands take the normal WIDTH-cycle RUN path.
// TESTING
//  - 3 x 5 with start pulsed one cycle:
//    - busy high for exactly 4 cycles, then done for 1 cycle.
//    - product=8'h0F; busy and done are never high together.
//  - 15 x 15: product=8'hE1 (225); add_cout is exercised on the final step.
//  - Exhaustive 16x16 operand sweep, back-to-back (start held high):
//    - every product matches a*b.
//    - done spacing is 5 cycles.
//  - start re-pulsed with new operands in the 2nd RUN cycle of 7 x 9:
//    - ignored; product=8'h3F at done.
//  - rst asserted asynchronously (mid-cycle) during RUN of 6 x 6:
//    - all outputs 0 immediately; IDLE; no done.
//    - next 2 x 3 gives 8'h06.
//  - 0 x 9:
//    - with MULT_ZERO_SKIP_EN: done 1 cycle after start, product=0, busy=0.
//    - without it: done after 5 cycles, product=0.

Source files
------------

// File: rtl/shift_add_mult4.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult4
//  Purpose  : Sequential shift-and-add unsigned multiplier. Forms one partial
//             product per clock using an external WIDTH-bit ripple adder and
//             delivers a 2*WIDTH-bit product together with a one-cycle done.
//  Ports    : clk, rst          - rising-edge clock, async active-high reset
//             start             - request, honoured only in IDLE or DONE
//             a_in, b_in        - multiplicand / multiplier, captured at start
//             add_a, add_b      - operands driven to the external adder
//             add_sum, add_cout - combinational result from that adder
//             product           - result, held until the next completion
//             busy, done        - state decodes (RUN / DONE)
//  Options  : MULT_ZERO_SKIP_EN - a zero operand at start jumps straight to
//             DONE with product 0, skipping the RUN phase.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult4 #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Count value seen on the edge that performs the final RUN step.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]   mplr_q,    mplr_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               w_accept;
    logic               w_zero_skip;
    logic               w_last_step;
    logic [2*WIDTH-1:0] w_step;

    // A new operation may begin from IDLE, or straight out of DONE so that
    // back-to-back multiplies lose no cycle.
    assign w_accept    = start && ((state_q == c_st_idle) || (state_q == c_st_done));
    assign w_last_step = (cnt_q == c_cnt_last);

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero_skip = (a_in == '0) || (b_in == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // One shift-add step: adder result (carry kept) becomes the new upper
    // half, and the consumed multiplier bit falls off the bottom.
    assign w_step = {add_cout, add_sum, mplr_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_st_idle;
            acc_hi_q  <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            mplr_q    <= mplr_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    state_d = w_zero_skip ? c_st_done : c_st_run;
                end else begin
                    state_d = c_st_idle;
                end
            end
            c_st_run: begin
                // start is deliberately not looked at here.
                if (w_last_step) begin
                    state_d = c_st_done;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        acc_hi_d  = acc_hi_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        if (w_accept) begin
            mcand_d  = a_in;
            mplr_d   = b_in;
            acc_hi_d = '0;
            cnt_d    = '0;
            if (w_zero_skip) begin
                product_d = '0;
            end
        end else if (state_q == c_st_run) begin
            acc_hi_d = w_step[2*WIDTH-1:WIDTH];
            mplr_d   = w_step[WIDTH-1:0];
            cnt_d    = cnt_q + 1'b1;
            if (w_last_step) begin
                product_d = w_step;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state, no glitch paths
    // ------------------------------------------------------------------
    always_comb begin
        add_a   = acc_hi_q;
        add_b   = mplr_q[0] ? mcand_q : '0;
        busy    = (state_q == c_st_run);
        done    = (state_q == c_st_done);
        product = product_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult4
//  Purpose  : Self-checking bench for shift_add_mult4 with a behavioural
//             ripple-adder model attached to the adder ports. Expected
//             products come from plain a*b; expected timing from the
//             documented latency rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult4;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // External adder as a plain arithmetic sum.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    shift_add_mult4 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .product  (product),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Edges from the accepted start edge until done is first seen high.
    function automatic int exp_latency(input int a, input int b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Called just after the accepted start edge; steps until done or budget.
    task automatic wait_done(output int lat, output int busy_n, output int overlap);
        lat = 1; busy_n = 0; overlap = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1;
    endtask

    task automatic run_mult(input int a, input int b, input string tag);
        int lat, busy_n, overlap, el;
        el = exp_latency(a, b);
        @(negedge clk);
        start = 1'b1; a_in = 4'(a); b_in = 4'(b);
        @(posedge clk); #1;
        start = 1'b0; a_in = 4'($urandom); b_in = 4'($urandom);
        wait_done(lat, busy_n, overlap);
        check({tag, " product"}, 32'(product), 32'(a * b));
        check({tag, " latency"}, lat, el);
        check({tag, " busy cycles"}, busy_n, el - 1);
        check({tag, " busy&done"}, overlap, 0);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, 32'(done), 0);
        check({tag, " product held"}, 32'(product), 32'(a * b));
    endtask

    initial begin : main
        int lat, busy_n, overlap, seen_done, ra, rb, na, nb;

        // Reset state
        #1;
        check("reset product", 32'(product), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset add_a", 32'(add_a), 0);
        check("reset add_b", 32'(add_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_mult(3, 5, "3x5");
        check("3x5 hex", 32'(product), 32'h0F);
        run_mult(15, 15, "15x15");
        check("15x15 hex", 32'(product), 32'hE1);
        run_mult(0, 9, "0x9");
        run_mult(9, 0, "9x0");

        // start re-pulsed during RUN of 7x9 must be ignored
        @(negedge clk);
        start = 1'b1; a_in = 4'd7; b_in = 4'd9;
        @(posedge clk); #1;                 // E0, RUN cycle 1
        start = 1'b0;
        @(posedge clk); #1;                 // E1, RUN cycle 2
        @(negedge clk);
        start = 1'b1; a_in = 4'd2; b_in = 4'd2;
        @(posedge clk); #1;                 // E2 sees start in RUN
        start = 1'b0;
        lat = 0;
        wait_done(lat, busy_n, overlap);
        check("restart-ignored product", 32'(product), 32'h3F);
        check("restart-ignored latency", lat + 2, WIDTH + 1);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN of 6x6
        @(negedge clk);
        start = 1'b1; a_in = 4'd6; b_in = 4'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 0);
        check("async rst done", 32'(done), 0);
        check("async rst product", 32'(product), 0);
        check("async rst add_a", 32'(add_a), 0);
        check("async rst add_b", 32'(add_b), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        check("no done/busy after abort", seen_done, 0);
        run_mult(2, 3, "2x3 after rst");
        check("2x3 hex", 32'(product), 32'h06);

        // Random operands
        for (int i = 0; i < 16; i++) begin
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            run_mult(ra, rb, "random");
        end

        // Exhaustive back-to-back sweep with start held high
        @(negedge clk);
        start = 1'b1; a_in = 4'd0; b_in = 4'd0;
        @(posedge clk); #1;                 // pair 0 accepted
        for (int k = 0; k < 256; k++) begin
            if (k < 255) begin
                na = (k + 1) >> 4; nb = (k + 1) & 15;
                a_in = 4'(na); b_in = 4'(nb);
            end else begin
                start = 1'b0;
                a_in = 4'($urandom); b_in = 4'($urandom);
            end
            wait_done(lat, busy_n, overlap);
            check("sweep product", 32'(product), 32'((k >> 4) * (k & 15)));
            check("sweep done spacing", lat, exp_latency(k >> 4, k & 15));
            check("sweep busy&done", overlap, 0);
            @(posedge clk); #1;             // next pair accepted from DONE
        end
        check("sweep ends idle", 32'({busy, done}), 0);
        check("sweep final product", 32'(product), 32'd225);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
